// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings and the mul/div FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[1];
    endfunction

    // MULHU and REMU both read the upper half of the shared accumulator
    function automatic logic op_is_high(input muldiv_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd};
        acc_next = {sum, acc[WIDTH-1:1]};
        // Divide: acc = {remainder, quotient}; a clear borrow means the subtract sticks
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with fixed 33-cycle latency and register-bank writeback.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic [WIDTH-1:0] wb_data,
    output logic [4:0]       wb_sel,
    output logic             wb_en
);

    muldiv_state_e      state;
    muldiv_op_e         op_q;
    logic [4:0]         rd_q;
    logic [4:0]         cnt_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   result;
    logic               is_div;
    muldiv_op_e         op_in;

    assign op_in  = muldiv_op_e'(op);
    assign is_div = op_is_div(op_q);
    assign result = op_is_high(op_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    // busy and wb_en are registered and trail the state by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_MUL;
            rd_q    <= 5'd0;
            cnt_q   <= 5'd0;
            opnd_q  <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            busy    <= 1'b0;
            wb_en   <= 1'b0;
            wb_data <= {WIDTH{1'b0}};
            wb_sel  <= 5'd0;
        end else begin
            busy  <= (state != ST_IDLE);
            wb_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // the !busy gate drops a start in the cycle right after DONE
                    if (start && !busy) begin
                        op_q   <= op_in;
                        rd_q   <= rd;
                        cnt_q  <= 5'd0;
                        opnd_q <= op_is_div(op_in) ? opb : opa;
                        acc_q  <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? opa : opb)};
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wb_en   <= (rd_q != 5'd0);
                    wb_data <= result;
                    wb_sel  <= rd_q;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and random operations against an arithmetic reference.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        busy;
    logic [31:0] wb_data;
    logic [4:0]  wb_sel;
    logic        wb_en;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .rd      (rd),
        .busy    (busy),
        .wb_data (wb_data),
        .wb_sel  (wb_sel),
        .wb_en   (wb_en)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at edge N, watch edges N+1..N+35; optionally hammer start with junk operands
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit hammer);
        logic [31:0] exp;
        int pulses;
        exp = ref_result(o, a, b);
        pulses = 0;
        @(negedge clk);
        op = o; opa = a; opb = b; rd = r; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start = hammer && (k <= 33);
            op  = 2'($urandom);
            opa = $urandom;
            opb = $urandom;
            rd  = 5'($urandom_range(1, 31));
            @(posedge clk);
            #1;
            if (wb_en === 1'b1) pulses++;
            chk($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, (k <= 33)});
            chk($sformatf("wb_en_k%0d", k), {31'd0, wb_en}, {31'd0, (k == 33) && (r != 5'd0)});
            if (r != 5'd0 && (k == 33 || k == 35)) begin
                chk($sformatf("wb_data_op%0d_k%0d", o, k), wb_data, exp);
                chk($sformatf("wb_sel_k%0d", k), {27'd0, wb_sel}, {27'd0, r});
            end
        end
        chk("pulse_count", pulses, (r != 5'd0) ? 1 : 0);
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0; start = 1'b1; op = 2'd0; opa = 32'd7; opb = 32'd9; rd = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_sel", {27'd0, wb_sel}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b0);
        run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 5'd5, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 5'd5, 1'b0);
        run_op(2'd2, 32'd5, 32'd0, 5'd6, 1'b0);
        run_op(2'd3, 32'd5, 32'd0, 5'd6, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 5'd5, 1'b1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0);
        run_op(2'd2, 32'h0000_0003, 32'hFFFF_FFFF, 5'd1, 1'b0);

        // Abort a MUL with reset after edge N+10
        @(negedge clk);
        op = 2'd0; opa = 32'h1234_5678; opb = 32'h9ABC_DEF0; rd = 5'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wb_en", {31'd0, wb_en}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (wb_en !== 1'b0 || busy !== 1'b0) pulses++;
        end
        chk("abort_no_activity", pulses, 0);
        run_op(2'd0, 32'd3, 32'd4, 5'd9, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
            run_op(2'($urandom), ra, rb, 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to start an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 0 MUL (low word), 1 MULHU (high word, unsigned), 2 DIVU (quotient), 3 REMU (remainder).
REQ-006 opa  input  WIDTH  first operand (multiplicand or dividend), unsigned.
REQ-007 opb  input  WIDTH  second operand (multiplier or divisor), unsigned.
REQ-008 rd  input  5  destination register index, captured with the operands.
REQ-009 busy  output  1  high while an operation is in progress (BUSY or DONE).
REQ-010 wb_data  output  WIDTH  result, drives the register bank busC.
REQ-011 wb_sel  output  5  destination index, drives the register bank busCsel.
REQ-012 wb_en  output  1  one-cycle write strobe, drives the register bank en.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture op, opa, opb and rd, clear the 5-bit iteration counter, and move the FSM to BUSY.
REQ-015 In BUSY, one shift-add (multiply) or restoring shift-subtract (divide) step SHALL be performed per cycle, for exactly WIDTH cycles; the counter SHALL move the FSM to DONE when it wraps from 31 to 0.
REQ-016 The multiply SHALL form the full 2*WIDTH-bit unsigned product: MUL returns bits [31:0] and MULHU returns bits [63:32].
REQ-017 The divide SHALL produce the unsigned quotient and remainder: DIVU returns the quotient and REMU returns the remainder.
REQ-018 Divide by zero SHALL take the full latency and return quotient 0xFFFFFFFF and remainder equal to opa.
REQ-019 In DONE, wb_en SHALL be high for exactly one cycle, with wb_data and wb_sel valid in that cycle; the FSM SHALL then return to IDLE.
REQ-020 If rd=0, wb_en SHALL stay low in DONE; all other timing SHALL be unchanged.
REQ-021 Latency SHALL be constant: with start sampled at edge N, wb_en SHALL be high between edges N+33 and N+34, and busy SHALL be high from edge N+1 to edge N+34.
REQ-022 start while busy=1 SHALL be ignored, with no queuing; start in the DONE cycle SHALL also be ignored.
REQ-023 Input changes after capture SHALL NOT affect the result.
REQ-024 wb_data and wb_sel SHALL hold their last values until the next DONE; wb_en SHALL be low outside DONE.
REQ-025 Unused op encodings do not exist, because all 4 values of the 2-bit op field are defined.

Reset
REQ-026 Reset low SHALL immediately force: FSM IDLE, busy=0, wb_en=0, wb_data=0, wb_sel=0, counter=0, and all operand and accumulator registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no write strobe; after reset release the block SHALL accept a new start normally.
REQ-028 start SHALL be ignored while reset is low.

Structure
REQ-029 The op encodings and the FSM state encoding SHALL reside in the shared CPU package, cpu_pkg.
REQ-030 One combinational sub-module, muldiv_step, SHALL be used, performing a single multiply or divide iteration; the FSM, counter and registers SHALL stay in mul_div_unit.
REQ-031 The datapath SHALL share one 64-bit accumulator register between multiply (product) and divide (remainder:quotient).

Verification
REQ-032 MUL with opa=0x00010000, opb=0x00010000, rd=3 -> wb_data=0x00000000 and wb_sel=3, with wb_en pulsing once at edge N+33; MULHU with the same operands -> wb_data=0x00000001.
REQ-033 DIVU with opa=100, opb=7, rd=5 -> wb_data=14; REMU with the same operands -> wb_data=2.
REQ-034 DIVU with opa=5, opb=0 -> wb_data=0xFFFFFFFF; REMU with the same operands -> wb_data=5; both with the 33-cycle latency.
REQ-035 A second start with different operands at edges N+1..N+33 -> ignored; exactly one wb_en pulse, carrying the first result.
REQ-036 Reset pulsed at edge N+10 of a MUL -> busy=0 and wb_en=0 immediately, no strobe afterwards; a following MUL with opa=3, opb=4 -> wb_data=12.
REQ-037 MULHU with opa=0xFFFFFFFF, opb=0xFFFFFFFF, rd=0 -> no wb_en pulse, busy timing unchanged.
